// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants for the 8-digit status display
package display_pkg;

  localparam int NUM_DIGITS = 8;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // Digit roles by scan index; index 0 is the rightmost digit
  localparam logic [2:0] IDX_NIB0   = 3'd0;
  localparam logic [2:0] IDX_NIB1   = 3'd1;
  localparam logic [2:0] IDX_NIB2   = 3'd2;
  localparam logic [2:0] IDX_NIB3   = 3'd3;
  localparam logic [2:0] IDX_STATUS = 3'd4;
  localparam logic [2:0] IDX_LAST   = 3'd7;

endpackage

// File: rtl/hex_to_7seg.sv
// rtl/hex_to_7seg.sv - combinational hex nibble to active-low 7-segment decoder
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] segments
);

  // Table lookup; blank overrides the nibble entirely
  always_comb begin
    segments = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'h0: segments = SEG_0;
        4'h1: segments = SEG_1;
        4'h2: segments = SEG_2;
        4'h3: segments = SEG_3;
        4'h4: segments = SEG_4;
        4'h5: segments = SEG_5;
        4'h6: segments = SEG_6;
        4'h7: segments = SEG_7;
        4'h8: segments = SEG_8;
        4'h9: segments = SEG_9;
        4'hA: segments = SEG_A;
        4'hB: segments = SEG_B;
        4'hC: segments = SEG_C;
        4'hD: segments = SEG_D;
        4'hE: segments = SEG_E;
        default: segments = SEG_F;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_status_display.sv
// rtl/seven_seg_status_display.sv - time-multiplexed ALU value/flags/status display
module seven_seg_status_display
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 12500,
  parameter bit BLANK_ZEROS = 1'b1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [15:0] Value,
  input  logic [3:0]  Flags,
  input  logic [2:0]  Status,
  output logic [6:0]  Segments,
  output logic        DP,
  output logic [7:0]  Anodes,
  output logic        FrameTick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] prescale;
  logic [2:0]    idx;
  logic [15:0]   value_sh;
  logic [3:0]    flags_sh;
  logic [2:0]    status_sh;
  logic          term;
  logic          frame_load;
  logic [15:0]   value_shifted;
  logic [3:0]    nibble;
  logic          blank;
  logic [6:0]    seg_next;
  logic          dp_next;
  logic [7:0]    anodes_next;

  assign term       = (prescale == PRE_LAST);
  assign frame_load = term && (idx == IDX_LAST);
  assign FrameTick  = frame_load;

  // Prescaler and scan index: the index steps once per digit period
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      prescale <= '0;
      idx      <= '0;
    end else if (term) begin
      prescale <= '0;
      idx      <= idx + 3'd1;
    end else begin
      prescale <= prescale + PW'(1);
    end
  end

  // Frame snapshot: inputs are captured only at the end of the last digit
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      value_sh  <= '0;
      flags_sh  <= '0;
      status_sh <= '0;
    end else if (frame_load) begin
      value_sh  <= Value;
      flags_sh  <= Flags;
      status_sh <= Status;
    end
  end

  assign value_shifted = value_sh >> {idx[1:0], 2'b00};

  // Digit content select, leading-zero suppression and decimal point map
  always_comb begin
    nibble      = 4'h0;
    blank       = 1'b1;
    dp_next     = 1'b1;
    anodes_next = ~(8'b1 << idx);
    case (idx)
      IDX_NIB0: begin
        nibble = value_shifted[3:0];
        blank  = 1'b0;
      end
      IDX_NIB1, IDX_NIB2, IDX_NIB3: begin
        nibble = value_shifted[3:0];
        blank  = BLANK_ZEROS && (value_shifted == 16'h0000);
      end
      IDX_STATUS: begin
        nibble  = {1'b0, status_sh};
        blank   = 1'b0;
        dp_next = ~flags_sh[0];
      end
      default: begin
        // idx5..7 carry only decimal points: C, Z, N
        dp_next = ~flags_sh[idx[1:0]];
      end
    endcase
  end

  hex_to_7seg u_hex_to_7seg (
    .nibble   (nibble),
    .blank    (blank),
    .segments (seg_next)
  );

  // Registered pin drivers; reset forces every digit dark
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      Anodes   <= 8'hFF;
      Segments <= SEG_BLANK;
      DP       <= 1'b1;
    end else begin
      Anodes   <= anodes_next;
      Segments <= seg_next;
      DP       <= dp_next;
    end
  end

endmodule
